// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared seven-segment definitions for the hex-to-segment encoder
//            and the segment-to-hex readback decoder.
// Contents : seg_t          - one active-low segment bus, bit 0 = segment a
//            SEG_PATTERNS   - active-low glyphs for nibbles 0..F
//            SEG_BLANK      - fully dark digit
//            hs_state_e     - valid/ready handshake state
//            idx_width()    - index width helper, never below 1 bit
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // One digit, active-low, bit6..bit0 = g..a.
  typedef logic [6:0] seg_t;

  // A digit with every segment off.
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Glyph table indexed by the nibble it represents.
  localparam seg_t SEG_PATTERNS [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Output handshake: IDLE has nothing pending, HOLD presents a word.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hs_state_e;

  // Width of an index into N items; a single item still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_pattern_decode
// Purpose  : Combinational decode of one active-low seven-segment digit back
//            to the nibble it displays.
// Ports    : seg_i      in  7  active-low segment bus, bit 0 = segment a
//            nibble_o   out 4  decoded value (0 when blank or invalid)
//            blank_o    out 1  digit is fully dark
//            invalid_o  out 1  pattern is neither a glyph nor blank
// Revision : 1.0 - initial release
// ============================================================================
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = 4'h0;
    blank_o   = 1'b0;
    invalid_o = 1'b1;
    if (seg_i == SEG_BLANK) begin
      blank_o   = 1'b1;
      invalid_o = 1'b0;
    end else begin
      // Glyphs are unique, so at most one entry can match.
      for (int i = 0; i < 16; i++) begin
        if (seg_i == SEG_PATTERNS[i]) begin
          nibble_o  = 4'(i);
          invalid_o = 1'b0;
        end
      end
    end
  end

endmodule : seg_pattern_decode
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_decoder
// Purpose  : Display readback monitor. Watches NDIGITS active-low segment
//            buses, waits until the whole word has been stable for
//            STABLE_CYCLES clocks, decodes it to hex nibbles and offers each
//            new word on a valid/ready handshake.
// Ports    : clk         in  1            system clock
//            reset       in  1            synchronous active-high reset
//            hex_in      in  7*NDIGITS    digit i at [7i+6:7i], active-low
//            ready       in  1            consumer accepts the word
//            value       out 4*NDIGITS    decoded nibbles, digit i at [4i+3:4i]
//            blank_mask  out NDIGITS      digit i was fully dark
//            valid       out 1            value/blank_mask hold a pending word
//            err         out 1            pulse: qualified word undecodable
//            err_digit   out ERR_W        lowest undecodable digit index
//            overrun     out 1            pulse: pending word overwritten
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter  int NDIGITS       = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int ERR_W         = idx_width(NDIGITS),
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7*NDIGITS-1:0]   hex_in,
  input  logic                   ready,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     blank_mask,
  output logic                   valid,
  output logic                   err,
  output logic [ERR_W-1:0]       err_digit,
  output logic                   overrun
);

  localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7*NDIGITS-1:0] s_q,         s_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic                 reported_q,  reported_d;
  logic [7*NDIGITS-1:0] last_q,      last_d;
  hs_state_e            state_q,     state_d;
  logic [4*NDIGITS-1:0] value_q,     value_d;
  logic [NDIGITS-1:0]   blank_q,     blank_d;
  logic                 err_q,       err_d;
  logic [ERR_W-1:0]     err_digit_q, err_digit_d;
  logic                 overrun_q,   overrun_d;

  // --------------------------------------------------------------------------
  // Per-digit decode of the incoming word. On a qualifying edge hex_in equals
  // the sampled word, so decoding hex_in directly avoids an extra stage.
  // --------------------------------------------------------------------------
  logic [4*NDIGITS-1:0] w_nibbles;
  logic [NDIGITS-1:0]   w_blank;
  logic [NDIGITS-1:0]   w_invalid;

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
    seg_pattern_decode u_dec (
      .seg_i     (hex_in[7*gi +: 7]),
      .nibble_o  (w_nibbles[4*gi +: 4]),
      .blank_o   (w_blank[gi]),
      .invalid_o (w_invalid[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Qualification and event decode
  // --------------------------------------------------------------------------
  logic             w_same;
  logic             w_qual;
  logic             w_new;
  logic             w_load;
  logic             w_bad;
  logic             w_xfer;
  logic [ERR_W-1:0] w_err_idx;

  assign w_same = (hex_in == s_q);
  // cnt saturates at STABLE_CYCLES, so this matches once per stable run.
  assign w_qual = w_same && (cnt_q == CNT_QUAL);
  // A word equal to the last reported one is a glitch returning to the
  // previous display and is swallowed.
  assign w_new  = w_qual && !(reported_q && (hex_in == last_q));
  assign w_bad  = w_new && (|w_invalid);
  assign w_load = w_new && !(|w_invalid);
  assign w_xfer = (state_q == HOLD) && ready;

  // Lowest-index invalid digit wins: scan high to low so the last hit sticks.
  always_comb begin
    w_err_idx = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      if (w_invalid[i]) begin
        w_err_idx = ERR_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s_d         = hex_in;
    cnt_d       = cnt_q;
    reported_d  = reported_q;
    last_d      = last_q;
    state_d     = state_q;
    value_d     = value_q;
    blank_d     = blank_q;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;
    overrun_d   = 1'b0;

    // Stability filter
    if (!w_same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Both outcomes of a new word remember it, so a repeat is suppressed.
    if (w_new) begin
      last_d     = hex_in;
      reported_d = 1'b1;
    end

    if (w_bad) begin
      err_d       = 1'b1;
      err_digit_d = w_err_idx;
    end

    // Handshake. A load always leaves HOLD; a load over an untaken word
    // is an overrun, while a load coinciding with a transfer is not.
    if (w_load) begin
      value_d   = w_nibbles;
      blank_d   = w_blank;
      state_d   = HOLD;
      overrun_d = (state_q == HOLD) && !ready;
    end else if (w_xfer) begin
      state_d   = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '1;
      cnt_q       <= '0;
      reported_q  <= 1'b0;
      last_q      <= '1;
      state_q     <= IDLE;
      value_q     <= '0;
      blank_q     <= '0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      reported_q  <= reported_d;
      last_q      <= last_d;
      state_q     <= state_d;
      value_q     <= value_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
      overrun_q   <= overrun_d;
    end
  end

  assign value      = value_q;
  assign blank_mask = blank_q;
  assign valid      = (state_q == HOLD);
  assign err        = err_q;
  assign err_digit  = err_digit_q;
  assign overrun    = overrun_q;

endmodule : seven_seg_decoder
`default_nettype wire

// File: tb/tb_seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_decoder
// Purpose  : Self-checking bench for seven_seg_decoder: directed scenarios
//            followed by randomized words, all compared every cycle against a
//            sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic            clk = 1'b0;
  logic            reset;
  logic [7*ND-1:0] hex_in;
  logic            ready;
  logic [4*ND-1:0] value;
  logic [ND-1:0]   blank_mask;
  logic            valid;
  logic            err;
  logic [1:0]      err_digit;
  logic            overrun;

  seven_seg_decoder #(
    .NDIGITS       (ND),
    .STABLE_CYCLES (SC)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .hex_in     (hex_in),
    .ready      (ready),
    .value      (value),
    .blank_mask (blank_mask),
    .valid      (valid),
    .err        (err),
    .err_digit  (err_digit),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: keeps the recent sampled words; a word qualifies on the
  // edge where it has been seen on exactly SC+1 consecutive samples (the
  // reset value of the sampler counts as a sample).
  // --------------------------------------------------------------------------
  logic [7*ND-1:0] hist [$];
  bit              m_valid, m_err, m_overrun, m_reported;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_blank;
  int              m_err_digit;
  logic [7*ND-1:0] m_last;

  function automatic bit qual_now();
    int n;
    logic [7*ND-1:0] w;
    n = hist.size();
    if (n < SC + 1) return 1'b0;
    w = hist[n-1];
    for (int j = 1; j <= SC; j++)
      if (hist[n-1-j] != w) return 1'b0;
    if (n > SC + 1 && hist[n-2-SC] == w) return 1'b0;
    return 1'b1;
  endfunction

  task automatic dec_digit(input logic [6:0] p, output logic [3:0] nib,
                           output bit blk, output bit inv);
    nib = 4'h0; blk = 1'b0; inv = 1'b1;
    if (p == 7'h7F) begin
      blk = 1'b1; inv = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++)
        if (p == TBL[k]) begin nib = 4'(k); inv = 1'b0; end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back('1);
    m_valid = 0; m_err = 0; m_overrun = 0; m_reported = 0;
    m_value = '0; m_blank = '0; m_err_digit = 0; m_last = '1;
  endtask

  task automatic model_edge(input logic [7*ND-1:0] h, input bit r);
    bit xfer, bad, blk, inv;
    int idx;
    logic [3:0] nib;
    logic [4*ND-1:0] nv;
    logic [ND-1:0] nb;
    hist.push_back(h);
    while (hist.size() > SC + 2) void'(hist.pop_front());
    m_err = 0; m_overrun = 0;
    xfer = m_valid && r;
    if (qual_now() && !(m_reported && h == m_last)) begin
      bad = 0; idx = 0; nv = '0; nb = '0;
      for (int d = 0; d < ND; d++) begin
        dec_digit(h[7*d +: 7], nib, blk, inv);
        nv[4*d +: 4] = nib;
        nb[d] = blk;
        if (inv && !bad) begin bad = 1; idx = d; end
      end
      m_last = h; m_reported = 1;
      if (bad) begin
        m_err = 1; m_err_digit = idx;
        if (xfer) m_valid = 0;
      end else begin
        m_overrun = m_valid && !r;
        m_value = nv; m_blank = nb; m_valid = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive, clock, update model, then compare away from the edge.
  task automatic step(input logic [7*ND-1:0] h, input bit r, input bit rst);
    hex_in = h; ready = r; reset = rst;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(h, r);
    #1;
    check("valid",      valid,      m_valid);
    check("value",      value,      m_value);
    check("blank_mask", blank_mask, m_blank);
    check("err",        err,        m_err);
    check("err_digit",  err_digit,  m_err_digit);
    check("overrun",    overrun,    m_overrun);
  endtask

  task automatic hold(input logic [7*ND-1:0] h, input int n, input bit r);
    for (int i = 0; i < n; i++) step(h, r, 1'b0);
  endtask

  function automatic logic [7*ND-1:0] mk(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
    return {TBL[a], TBL[b], TBL[c], TBL[d]};
  endfunction

  function automatic logic [6:0] rand_digit();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)  return TBL[$urandom_range(0, 15)];
    if (sel == 7) return 7'h7F;
    return 7'($urandom);
  endfunction

  logic [7*ND-1:0] w1234, w1235, w5678, w9abc, wbad, wblank, w;
  logic [7*ND-1:0] pool [3];
  bit              seen;

  initial begin
    w1234  = mk(4'h1, 4'h2, 4'h3, 4'h4);
    w1235  = mk(4'h1, 4'h2, 4'h3, 4'h5);
    w5678  = mk(4'h5, 4'h6, 4'h7, 4'h8);
    w9abc  = mk(4'h9, 4'hA, 4'hB, 4'hC);
    wbad   = {TBL[1], 7'b1111110, TBL[3], TBL[4]};
    wblank = {7'h7F, TBL[0], TBL[0], TBL[15]};
    hex_in = '1; ready = 1'b0; reset = 1'b1;
    model_reset();

    // Reset state
    step(w1234, 1'b0, 1'b1);
    step(w1234, 1'b0, 1'b1);
    check("rst_valid", valid, 0);
    check("rst_value", value, 0);

    // First word: qualifies on the SC-th edge after the change edge
    hold(w1234, SC, 1'b0);
    check("pre_qual_valid", valid, 0);
    step(w1234, 1'b0, 1'b0);
    check("q1_valid", valid, 1);
    check("q1_value", value, 32'h1234);
    check("q1_blank", blank_mask, 0);
    hold(w1234, 19, 1'b0);
    check("hold_value", value, 32'h1234);
    step(w1234, 1'b1, 1'b0);
    check("xfer_valid", valid, 0);

    // Glitch A->B->A is swallowed
    seen = 0;
    for (int i = 0; i < 2; i++) begin step(w1235, 1'b0, 1'b0); seen |= valid | err; end
    for (int i = 0; i < 8; i++) begin step(w1234, 1'b0, 1'b0); seen |= valid | err; end
    check("glitch_quiet", seen, 0);
    hold(w1235, SC + 1, 1'b0);
    check("q1235_value", value, 32'h1235);
    step(w1235, 1'b1, 1'b0);

    // Undecodable digit 2
    hold(wbad, SC, 1'b0);
    step(wbad, 1'b0, 1'b0);
    check("err_pulse", err, 1);
    check("err_digit", err_digit, 2);
    check("err_valid", valid, 0);
    step(wbad, 1'b0, 1'b0);
    check("err_clear", err, 0);

    // Blank digit
    hold(wblank, SC + 1, 1'b0);
    check("blank_value", value, 32'h000F);
    check("blank_mask", blank_mask, 4'b1000);
    check("blank_valid", valid, 1);
    step(wblank, 1'b1, 1'b0);

    // Overrun: pending word replaced while ready is low
    hold(w1234, SC + 1, 1'b0);
    hold(w5678, SC + 1, 1'b0);
    check("ovr_pulse", overrun, 1);
    check("ovr_value", value, 32'h5678);
    check("ovr_valid", valid, 1);
    step(w5678, 1'b0, 1'b0);
    check("ovr_clear", overrun, 0);

    // Transfer and load on the same edge: no overrun
    hold(w1234, SC, 1'b0);
    step(w1234, 1'b1, 1'b0);
    check("same_ovr", overrun, 0);
    check("same_valid", valid, 1);
    check("same_value", value, 32'h1234);
    step(w1234, 1'b1, 1'b0);

    // Reset mid-filter (cnt=2), then mid-HOLD of the same word
    hold(w9abc, 3, 1'b0);
    step(w9abc, 1'b0, 1'b1);
    check("mrst_valid", valid, 0);
    check("mrst_value", value, 0);
    hold(w9abc, SC, 1'b0);
    check("mrst_wait", valid, 0);
    step(w9abc, 1'b0, 1'b0);
    check("mrst_q_value", value, 32'h9ABC);
    step(w9abc, 1'b0, 1'b1);
    hold(w9abc, SC + 1, 1'b0);
    check("hrst_requal", valid, 1);
    check("hrst_value", value, 32'h9ABC);
    step(w9abc, 1'b1, 1'b0);

    // Randomized words
    pool[0] = w1234; pool[1] = wbad; pool[2] = wblank;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        w = pool[$urandom_range(0, 2)];
      end else begin
        for (int d = 0; d < ND; d++) w[7*d +: 7] = rand_digit();
      end
      for (int c = 0, len = $urandom_range(1, 8); c < len; c++)
        step(w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_seven_seg_decoder
`default_nettype wire
